// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Purpose  : Shared types and helpers for the branch-predictor resolve queue.
//             Holds the default path-history width, the per-branch entry
//             layout and the final-prediction helper used at resolve time.
//  Revision : 1.0  initial release
// ============================================================================
package bp_pkg;

  // Default path-history / table-index width.
  localparam int c_HIST_W = 12;

  // The three component predictions captured at lookup time.
  // globalPred/localPred avoid the reserved words 'global' and 'local'.
  typedef struct packed {
    logic globalPred;
    logic localPred;
    logic choice;      // 1 = use global, 0 = use local
  } bp_pred_t;

  // Full in-flight entry at the default history width.
  typedef struct packed {
    logic [c_HIST_W-1:0] hist;
    logic                globalPred;
    logic                localPred;
    logic                choice;
  } bp_entry_t;

  // Final direction the front end actually followed for this branch.
  function automatic logic bp_final_pred(input bp_pred_t p);
    return p.choice ? p.globalPred : p.localPred;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bp_inflight_fifo
//  Purpose  : In-order storage for predicted branches awaiting resolution.
//             Power-of-two circular buffer with head/tail pointers, an
//             occupancy count and a squash input that empties it in one cycle.
//  Ports    : clock, reset (async, active-high)
//             push/pushData  - write at tail (ignored when full or squashing)
//             pop            - retire head (ignored when empty)
//             squash         - drop all entries: head = tail, count = 0
//             headData       - oldest entry, combinational
//             count          - occupied entries, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module bp_inflight_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            pushData,
  input  logic                         pop,
  input  logic                         squash,
  output logic [DATA_W-1:0]            headData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_pushOk;
  logic w_popOk;

  assign w_full   = (r_count == c_DEPTH_CNT);
  assign w_empty  = (r_count == '0);
  // Squash wins over a same-cycle push so a mispredict never keeps a
  // wrong-path branch.
  assign w_pushOk = push && !w_full && !squash;
  assign w_popOk  = pop && !w_empty;

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clock) begin
    if (w_pushOk) begin
      r_mem[r_tail] <= pushData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_tail <= r_tail + c_PTR_ONE;
      if (w_popOk)  r_head <= r_head + c_PTR_ONE;
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign headData = r_mem[r_head];
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/bp_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module   : bp_resolve_queue
//  Purpose  : Tracks in-flight predicted branches and, as the oldest one
//             resolves, emits the tournament-table update and, on a
//             misprediction, a recovery request with corrected history.
//  Ports    : clock, reset (async, active-high)
//             alloc_*        - new predicted branch (hist + 3 predictions)
//             alloc_ready    - queue not full (from count only)
//             resolve_*      - oldest branch outcome
//             upd_*          - registered table-update command
//             mispredict     - recovery pulse, recover_hist = corrected hist
//             count          - occupied entries
//             resolve_error  - resolve seen with an empty queue
//  Revision : 1.0  initial release
// ============================================================================
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HIST_W = c_HIST_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [HIST_W-1:0]           alloc_hist,
  input  logic                        alloc_global,
  input  logic                        alloc_local,
  input  logic                        alloc_choice,
  input  logic                        resolve_valid,
  input  logic                        resolve_taken,
  output logic                        upd_valid,
  output logic [HIST_W-1:0]           upd_index,
  output logic                        upd_taken,
  output logic                        upd_choice_en,
  output logic                        upd_choice_dir,
  output logic                        mispredict,
  output logic [HIST_W-1:0]           recover_hist,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        resolve_error
);

  localparam int c_PRED_W = $bits(bp_pred_t);
  localparam int c_DATA_W = HIST_W + c_PRED_W;
  localparam int c_CNT_W  = $clog2(DEPTH+1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [c_DATA_W-1:0] w_headData;
  logic [c_CNT_W-1:0]  w_count;
  logic [HIST_W-1:0]   w_headHist;
  bp_pred_t            w_headPred;
  bp_pred_t            w_allocPred;
  logic                w_allocReady;
  logic                w_empty;
  logic                w_doResolve;
  logic                w_mispredict;
  logic                w_push;

  logic                r_updValid;
  logic [HIST_W-1:0]   r_updIndex;
  logic                r_updTaken;
  logic                r_updChoiceEn;
  logic                r_updChoiceDir;
  logic                r_mispredict;
  logic [HIST_W-1:0]   r_recoverHist;
  logic                r_resolveError;

  assign w_allocPred = '{globalPred: alloc_global, localPred: alloc_local,
                         choice: alloc_choice};
  assign w_headHist  = w_headData[c_DATA_W-1 -: HIST_W];
  assign w_headPred  = bp_pred_t'(w_headData[c_PRED_W-1:0]);

  // Ready depends on registered occupancy only; a same-cycle resolve does
  // not free a slot for an alloc.
  assign w_allocReady = (w_count != c_DEPTH_CNT);
  assign w_empty      = (w_count == '0);
  assign w_doResolve  = resolve_valid && !w_empty;
  assign w_mispredict = w_doResolve &&
                        (bp_final_pred(w_headPred) != resolve_taken);
  assign w_push       = alloc_valid && w_allocReady && !w_mispredict;

  bp_inflight_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (c_DATA_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (w_push),
    .pushData ({alloc_hist, w_allocPred}),
    .pop      (w_doResolve),
    .squash   (w_mispredict),
    .headData (w_headData),
    .count    (w_count)
  );

  // Strobes pulse for one cycle; data fields hold until the next resolve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_updValid     <= 1'b0;
      r_updIndex     <= '0;
      r_updTaken     <= 1'b0;
      r_updChoiceEn  <= 1'b0;
      r_updChoiceDir <= 1'b0;
      r_mispredict   <= 1'b0;
      r_recoverHist  <= '0;
      r_resolveError <= 1'b0;
    end else begin
      r_updValid     <= w_doResolve;
      r_mispredict   <= w_mispredict;
      r_resolveError <= resolve_valid && w_empty;
      if (w_doResolve) begin
        r_updIndex     <= w_headHist;
        r_updTaken     <= resolve_taken;
        // The chooser only learns when the two components disagreed.
        r_updChoiceEn  <= (w_headPred.globalPred != w_headPred.localPred);
        r_updChoiceDir <= (w_headPred.globalPred == resolve_taken);
        r_recoverHist  <= {w_headHist[HIST_W-2:0], resolve_taken};
      end
    end
  end

  assign alloc_ready    = w_allocReady;
  assign count          = w_count;
  assign upd_valid      = r_updValid;
  assign upd_index      = r_updIndex;
  assign upd_taken      = r_updTaken;
  assign upd_choice_en  = r_updChoiceEn;
  assign upd_choice_dir = r_updChoiceDir;
  assign mispredict     = r_mispredict;
  assign recover_hist   = r_recoverHist;
  assign resolve_error  = r_resolveError;

endmodule
`default_nettype wire

// File: tb/tb_bp_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_resolve_queue
//  Purpose  : Directed self-checking bench for bp_resolve_queue with
//             hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_resolve_queue;

  localparam int DEPTH  = 8;
  localparam int HIST_W = 12;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              alloc_valid = 1'b0;
  logic              alloc_ready;
  logic [HIST_W-1:0] alloc_hist = '0;
  logic              alloc_global = 1'b0;
  logic              alloc_local = 1'b0;
  logic              alloc_choice = 1'b0;
  logic              resolve_valid = 1'b0;
  logic              resolve_taken = 1'b0;
  logic              upd_valid;
  logic [HIST_W-1:0] upd_index;
  logic              upd_taken;
  logic              upd_choice_en;
  logic              upd_choice_dir;
  logic              mispredict;
  logic [HIST_W-1:0] recover_hist;
  logic [3:0]        count;
  logic              resolve_error;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bp_resolve_queue #(.DEPTH(DEPTH), .HIST_W(HIST_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_hist     (alloc_hist),
    .alloc_global   (alloc_global),
    .alloc_local    (alloc_local),
    .alloc_choice   (alloc_choice),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .upd_valid      (upd_valid),
    .upd_index      (upd_index),
    .upd_taken      (upd_taken),
    .upd_choice_en  (upd_choice_en),
    .upd_choice_dir (upd_choice_dir),
    .mispredict     (mispredict),
    .recover_hist   (recover_hist),
    .count          (count),
    .resolve_error  (resolve_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic setAlloc(input logic v, input logic [HIST_W-1:0] h,
                          input logic g, input logic l, input logic c);
    alloc_valid  = v;
    alloc_hist   = h;
    alloc_global = g;
    alloc_local  = l;
    alloc_choice = c;
  endtask

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_index", 32'(upd_index), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_recover", 32'(recover_hist), 32'd0);
    chk("rst_res_err", 32'(resolve_error), 32'd0);

    // ---------------- correct prediction, chooser disagreement ----------------
    setAlloc(1'b1, 12'h0A5, 1'b1, 1'b0, 1'b1);
    step();
    chk("t1_count1", 32'(count), 32'd1);
    setAlloc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    resolve_valid = 1'b0;
    chk("t1_upd_valid", 32'(upd_valid), 32'd1);
    chk("t1_upd_index", 32'(upd_index), 32'h0A5);
    chk("t1_upd_taken", 32'(upd_taken), 32'd1);
    chk("t1_choice_en", 32'(upd_choice_en), 32'd1);
    chk("t1_choice_dir", 32'(upd_choice_dir), 32'd1);
    chk("t1_mispredict", 32'(mispredict), 32'd0);
    chk("t1_recover", 32'(recover_hist), 32'h14B);
    chk("t1_count", 32'(count), 32'd0);
    step();
    chk("t1_pulse_end", 32'(upd_valid), 32'd0);
    chk("t1_index_hold", 32'(upd_index), 32'h0A5);

    // ---------------- misprediction via local component ----------------
    setAlloc(1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0);
    step();
    setAlloc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    step();
    resolve_valid = 1'b0;
    chk("t2_mispredict", 32'(mispredict), 32'd1);
    chk("t2_recover", 32'(recover_hist), 32'hFFE);
    chk("t2_choice_en", 32'(upd_choice_en), 32'd0);
    chk("t2_choice_dir", 32'(upd_choice_dir), 32'd0);
    chk("t2_upd_index", 32'(upd_index), 32'hFFF);
    step();
    chk("t2_misp_pulse_end", 32'(mispredict), 32'd0);

    // ---------------- fill, full-with-resolve, wrap ----------------
    for (int i = 0; i < 8; i++) begin
      setAlloc(1'b1, 12'(12'h100 + i), 1'b1, 1'b1, 1'b1);
      step();
    end
    chk("t3_full_count", 32'(count), 32'd8);
    chk("t3_full_ready", 32'(alloc_ready), 32'd0);
    setAlloc(1'b1, 12'h1FF, 1'b1, 1'b1, 1'b1);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    chk("t3_drop_count", 32'(count), 32'd7);
    chk("t3_drop_index", 32'(upd_index), 32'h100);
    chk("t3_drop_misp", 32'(mispredict), 32'd0);
    chk("t3_ready_again", 32'(alloc_ready), 32'd1);
    // Alloc and resolve together: occupancy steady, order preserved.
    for (int i = 0; i < 9; i++) begin
      setAlloc(1'b1, 12'(12'h200 + i), 1'b1, 1'b1, 1'b1);
      step();
      chk("t3_wrap_index", 32'(upd_index), (i < 7) ? 32'(12'h101 + i) : 32'(12'h200 + i - 7));
      chk("t3_wrap_valid", 32'(upd_valid), 32'd1);
      chk("t3_wrap_count", 32'(count), 32'd7);
    end
    setAlloc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t3_drain_index", 32'(upd_index), 32'(12'h202 + i));
      chk("t3_drain_count", 32'(count), 32'(6 - i));
    end
    resolve_valid = 1'b0;
    step();

    // ---------------- mispredict squash with same-cycle alloc ----------------
    for (int i = 0; i < 4; i++) begin
      setAlloc(1'b1, 12'(12'h300 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("t4_count4", 32'(count), 32'd4);
    setAlloc(1'b1, 12'h3FF, 1'b0, 1'b0, 1'b0);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    step();
    setAlloc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    chk("t4_mispredict", 32'(mispredict), 32'd1);
    chk("t4_upd_index", 32'(upd_index), 32'h300);
    chk("t4_recover", 32'(recover_hist), 32'h601);
    chk("t4_count0", 32'(count), 32'd0);
    step();
    chk("t4_res_err", 32'(resolve_error), 32'd1);
    chk("t4_no_upd", 32'(upd_valid), 32'd0);
    chk("t4_no_misp", 32'(mispredict), 32'd0);
    chk("t4_count_still0", 32'(count), 32'd0);

    // ---------------- resolve on empty queue ----------------
    step();
    chk("t5_res_err", 32'(resolve_error), 32'd1);
    chk("t5_no_upd", 32'(upd_valid), 32'd0);
    chk("t5_index_hold", 32'(upd_index), 32'h300);
    resolve_valid = 1'b0;
    step();
    chk("t5_err_pulse_end", 32'(resolve_error), 32'd0);

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 5; i++) begin
      setAlloc(1'b1, 12'(12'h400 + i), 1'b1, 1'b0, 1'b1);
      step();
    end
    setAlloc(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    chk("t6_count5", 32'(count), 32'd5);
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    step();
    chk("t6_inflight_valid", 32'(upd_valid), 32'd1);
    chk("t6_inflight_misp", 32'(mispredict), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_ready", 32'(alloc_ready), 32'd1);
    chk("t6_async_valid", 32'(upd_valid), 32'd0);
    chk("t6_async_misp", 32'(mispredict), 32'd0);
    resolve_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("t6_post_valid", 32'(upd_valid), 32'd0);
    chk("t6_post_misp", 32'(mispredict), 32'd0);
    chk("t6_post_count", 32'(count), 32'd0);
    chk("t6_post_recover", 32'(recover_hist), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
